// File: rtl/instr_encoder.sv
// WISC-SP13 instruction encoder: packs field bundles into 16-bit words and
// streams them through a small FIFO into sequential instruction-memory writes.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [4:0]  opcode,
  input  logic [2:0]  rs,
  input  logic [2:0]  rt,
  input  logic [2:0]  rd,
  input  logic [10:0] imm,
  input  logic [1:0]  func,
  output logic        mem_wr_en,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic [15:0] words_written,
  output logic        range_err,
  output logic        done
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, accept, pop;
  logic [15:0]   enc_word;
  logic          enc_bad;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !rst && (state == S_RUN) && !full;
  assign accept    = in_valid && in_ready;
  assign pop       = !empty && mem_ready;
  assign mem_wr_en = !empty;
  assign mem_data  = empty ? '0 : fifo_q[rd_ptr];
  assign done      = (state == S_DONE);

  // Immediate fits when all bits above the field's sign bit replicate it.
  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    unique case (fmt)
      2'b11: enc_word = {opcode, rs, rt, rd, func};
      2'b01: begin
        enc_word = {opcode, rs, rd, imm[4:0]};
        enc_bad  = !((&imm[10:4]) || !(|imm[10:4]));
      end
      2'b10: begin
        enc_word = {opcode, rs, imm[7:0]};
        enc_bad  = !((&imm[10:7]) || !(|imm[10:7]));
      end
      default: enc_word = {opcode, imm};
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_q[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      mem_addr      <= BASE_ADDR;
      words_written <= '0;
      range_err     <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (enc_bad) range_err <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + AW'(1);
        mem_addr      <= mem_addr + 16'd2;
        words_written <= words_written + 16'd1;
      end
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // No pushes occur in DRAIN, so popping the sole entry empties the FIFO.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (accept && (opcode == 5'b00000)) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && (count == (AW+1)'(1)))   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_RUN;
    endcase
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Assembles WISC-SP13 instruction fields into 16-bit instruction words and writes them sequentially into instruction memory. It is the inverse of the decode stage: it packs opcode, register and immediate fields according to the same 2-bit format code the decoder uses to unpack them. It sits between the test loader / boot-ROM sequencer and the instruction-memory write port. A DEPTH-entry FIFO decouples field input from memory stalls, and a small FSM stops intake after HALT.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- BASE_ADDR, 16'h0000: first memory byte address; must be even.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- fmt  in  2  format code: 00 J, 01 I-format-1, 10 I-format-2, 11 R.
- opcode  in  5  instr[15:11].
- rs  in  3  source register 1.
- rt  in  3  source register 2 (R only).
- rd  in  3  destination register (R, I1).
- imm  in  11  immediate or displacement, two's complement.
- func  in  2  R-format function bits.
- mem_wr_en  out  1  write request.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  16  byte address.
- mem_data  out  16  encoded instruction.
- words_written  out  16  count of completed writes; wraps.
- range_err  out  1  sticky: an immediate did not fit its field.
- done  out  1  HALT written and FIFO empty.

## Operation
- Packing (combinational, on accept):
  - R: {opcode, rs, rt, rd, func}.
  - I1: {opcode, rs, rd, imm[4:0]}.
  - I2: {opcode, rs, imm[7:0]}.
  - J: {opcode, imm[10:0]}.
- Range check on accept:
  - I1: imm[10:4] must be all-equal.
  - I2: imm[10:7] must be all-equal.
  - J, R: no check.
  - On failure: range_err set; the truncated word is still pushed.
- FSM states: RUN, DRAIN, DONE. Reset state is RUN.
  - RUN → DRAIN when a bundle with opcode 5'b00000 (HALT) is accepted.
  - DRAIN → DONE on the cycle the last FIFO entry is written (pop leaves the FIFO empty).
  - DONE holds until rst.
- in_ready = !rst && state==RUN && !full. There is no push-through when full, even if a pop occurs in the same cycle.
- Accept = in_valid && in_ready. The encoded word is pushed at that edge.
- mem_wr_en = !empty. mem_data = FIFO head, mem_addr = address register; both are held stable while mem_wr_en && !mem_ready.
- Write completes when mem_wr_en && mem_ready. On that edge:
  - Pop the FIFO.
  - mem_addr += 2, wrapping 16'hFFFE → 16'h0000.
  - words_written += 1, wrapping.
- Simultaneous push and pop on a non-full FIFO: occupancy is unchanged and both take effect.
- done = (state==DONE).

## Timing
- Reset values: in_ready 0 while rst is high; mem_wr_en 0; mem_addr BASE_ADDR; mem_data 0 (empty FIFO); words_written 0; range_err 0; done 0; FIFO empty; state RUN.
- In the first cycle after rst deasserts, in_ready = 1.
- Latency: a bundle accepted at edge N into an empty FIFO gives mem_wr_en=1 with its word throughout cycle N+1.
- Sustained throughput is 1 word/cycle while mem_ready=1 and in_valid=1.
- A HALT accepted at edge N drops in_ready from cycle N+1 onward. done rises the cycle after the HALT word's write completes.
- rst mid-operation discards FIFO contents and returns every output to its reset value at the next edge. Any in-flight write with mem_ready high in that cycle is not counted.

## Test plan
- R pack: fmt=11, opcode=11011, rs=1, rt=2, rd=3, func=00 → one cycle later mem_wr_en=1, mem_data=16'hD94C, mem_addr=16'h0000. After a write with mem_ready=1: words_written=1, mem_addr=16'h0002.
- All formats back-to-back with mem_ready=1:
  - I1 opcode=01000, rs=1, rd=2, imm=11'h7FF → 16'h415F.
  - I2 opcode=11000, rs=5, imm=11'h012 → 16'hC512.
  - J opcode=00100, imm=11'h004 → 16'h2004.
  - Consecutive addresses 0, 2, 4; range_err stays 0.
- Backpressure: hold mem_ready=0 and push 4 bundles → in_ready=0 after the 4th. mem_data/mem_addr stay frozen on entry 0. Release mem_ready → 4 writes in order, in_ready returns to 1 the cycle after the first pop.
- Range error: I1 with imm=11'h010 → range_err=1 (sticky), mem_data low 5 bits = 5'b10000. A later J bundle leaves range_err=1.
- HALT/wrap: BASE_ADDR=16'hFFFE, push J then HALT (all-zero fields) → writes at FFFE then 0000 (data 16'h0000). in_ready=0 after HALT accept; done=1 after the second write; further in_valid is ignored.
- Reset mid-drain: three entries queued with mem_ready=0, assert rst for 1 cycle → mem_wr_en=0, mem_addr=BASE_ADDR, words_written=0, done=0. The next bundle is written at BASE_ADDR.
